// File: rtl/crc_check_pkg.sv
// -----------------------------------------------------------------------------
// crc_check_pkg
//   Shared types and helpers for the receive-side CRC checker.
//   - state_e : checker FSM encoding (IDLE/FILL/RUN)
//   - f_rev8  : bit-order reversal within one byte, used by the CRC output
//               transform when the link sends each CRC byte LSB-first
// -----------------------------------------------------------------------------
package crc_check_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_RUN  = 2'd2
   } state_e;

   function automatic logic [7:0] f_rev8(input logic [7:0] b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = b[7-i];
      return r;
   endfunction

endpackage

// File: rtl/crc_check_delay_line.sv
// -----------------------------------------------------------------------------
// crc_delay_line
//   N-word shift register holding the most recent N words of a frame, so the
//   trailing CRC words are never forwarded as payload. A new word always enters
//   at slot 0; once N words are held, a push displaces the oldest word (slot
//   N-1), which is reported on O_head/O_head_v as payload.
// Ports
//   I_clk, I_rst     clock, synchronous active-high reset
//   I_push           store I_data this cycle
//   I_clr            with I_push: this word starts a new frame (fill restarts at 1)
//   I_data           word to store
//   O_head           oldest held word
//   O_head_v         O_head is displaced by this cycle's push
//   O_fill           number of words currently held (0..N)
//   O_contents_nxt   line contents after this cycle's push, oldest word in MSBs
// -----------------------------------------------------------------------------
module crc_delay_line #(
   parameter int C_DWIDTH = 8,
   parameter int C_N      = 4
) (
   input  logic                          I_clk,
   input  logic                          I_rst,
   input  logic                          I_push,
   input  logic                          I_clr,
   input  logic [C_DWIDTH-1:0]           I_data,
   output logic [C_DWIDTH-1:0]           O_head,
   output logic                          O_head_v,
   output logic [$clog2(C_N+1)-1:0]      O_fill,
   output logic [C_N*C_DWIDTH-1:0]       O_contents_nxt
);

   localparam int CW = $clog2(C_N+1);

   logic [C_N-1:0][C_DWIDTH-1:0] mem_q, mem_d;
   logic [CW-1:0]                fill_q, fill_d;

   always_comb begin
      mem_d  = mem_q;
      fill_d = fill_q;
      if (I_push) begin
         for (int i = C_N-1; i > 0; i--) mem_d[i] = mem_q[i-1];
         mem_d[0] = I_data;
         // Stale words from an abandoned frame may remain in upper slots; they
         // are shifted out before fill reaches N again, so they never surface.
         if (I_clr)                     fill_d = CW'(1);
         else if (fill_q != CW'(C_N))   fill_d = fill_q + 1'b1;
      end
   end

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         mem_q  <= '0;
         fill_q <= '0;
      end else begin
         mem_q  <= mem_d;
         fill_q <= fill_d;
      end
   end

   assign O_head         = mem_q[C_N-1];
   assign O_head_v       = I_push & ~I_clr & (fill_q == CW'(C_N));
   assign O_fill         = fill_q;
   assign O_contents_nxt = mem_d;

endmodule

// File: rtl/crc_check.sv
// -----------------------------------------------------------------------------
// crc_check
//   Receive-side CRC checker. The last N = C_GEN_WIDTH/C_DWIDTH words of each
//   frame carry the CRC; they are held back in a delay line and stripped, the
//   remaining payload is forwarded and run through the CRC, and one verdict
//   pulse per frame reports the comparison against the received CRC.
// Ports
//   I_clk, I_rst          clock, synchronous active-high reset
//   I_data/I_data_v       input word stream
//   I_sof/I_eof           frame delimiters, qualified by I_data_v
//   O_data/O_data_v       payload words, registered one clock after displacement
//   O_data_eof            last payload word, coincident with O_chk_v
//   O_chk_v               one-cycle verdict pulse, one clock after the eof beat
//   O_chk_ok              received CRC matched
//   O_len_err             frame had no payload word (<= N words)
//   O_crc_calc            computed CRC after output transform
// -----------------------------------------------------------------------------
module crc_check
   import crc_check_pkg::*;
#(
   parameter int                     C_DWIDTH      = 8,
   parameter int                     C_GEN_WIDTH   = 32,
   parameter logic [C_GEN_WIDTH-1:0] C_GEN_SEQ     = 32'h04c11db7,
   parameter logic [C_GEN_WIDTH-1:0] C_INIT        = 32'hffffffff,
   parameter int                     C_IN_INVERT   = 0,
   parameter int                     C_BIT_REVERSE = 0,
   parameter int                     C_BYTE_INVERT = 0
) (
   input  logic                   I_clk,
   input  logic                   I_rst,
   input  logic [C_DWIDTH-1:0]    I_data,
   input  logic                   I_data_v,
   input  logic                   I_sof,
   input  logic                   I_eof,
   output logic [C_DWIDTH-1:0]    O_data,
   output logic                   O_data_v,
   output logic                   O_data_eof,
   output logic                   O_chk_v,
   output logic                   O_chk_ok,
   output logic                   O_len_err,
   output logic [C_GEN_WIDTH-1:0] O_crc_calc
);

   localparam int N  = C_GEN_WIDTH / C_DWIDTH;
   localparam int CW = $clog2(N+1);

   function automatic logic [C_DWIDTH-1:0] f_data_invert(input logic [C_DWIDTH-1:0] d);
      logic [C_DWIDTH-1:0] r;
      for (int i = 0; i < C_DWIDTH; i++) r[i] = d[C_DWIDTH-1-i];
      return r;
   endfunction

   // One word of CRC update, bit 0 of the (optionally reversed) word first.
   function automatic logic [C_GEN_WIDTH-1:0] f_crc_next(input logic [C_GEN_WIDTH-1:0] crc,
                                                         input logic [C_DWIDTH-1:0]    d);
      logic [C_DWIDTH-1:0] b;
      logic                fb;
      b = (C_IN_INVERT != 0) ? f_data_invert(d) : d;
      for (int i = 0; i < C_DWIDTH; i++) begin
         fb  = crc[C_GEN_WIDTH-1] ^ b[i];
         crc = {crc[C_GEN_WIDTH-2:0], 1'b0} ^ (fb ? C_GEN_SEQ : '0);
      end
      return crc;
   endfunction

   // Register value -> on-the-wire CRC representation.
   function automatic logic [C_GEN_WIDTH-1:0] f_byte_inv(input logic [C_GEN_WIDTH-1:0] c);
      logic [C_GEN_WIDTH-1:0] t;
      t = (C_BIT_REVERSE != 0) ? ~c : c;
      if (C_BYTE_INVERT != 0)
         for (int by = 0; by < C_GEN_WIDTH/8; by++) t[by*8 +: 8] = f_rev8(t[by*8 +: 8]);
      return t;
   endfunction

   state_e                 state_q, state_d;
   logic [C_GEN_WIDTH-1:0] crc_q, crc_d, crc_nxt;
   logic [C_DWIDTH-1:0]    data_q, data_d;
   logic                   data_v_q, data_v_d, data_eof_q, data_eof_d;
   logic                   chk_v_q, chk_v_d, chk_ok_q, chk_ok_d, len_err_q, len_err_d;
   logic [C_GEN_WIDTH-1:0] crc_calc_q, crc_calc_d;

   logic                   push, clr, head_v;
   logic [C_DWIDTH-1:0]    head;
   logic [CW-1:0]          fill;
   logic [C_GEN_WIDTH-1:0] contents_nxt;

   // Non-sof words are dropped while idle; a valid sof always (re)starts a frame.
   assign push = I_data_v & (I_sof | (state_q != ST_IDLE));
   assign clr  = I_data_v & I_sof;

   crc_delay_line #(.C_DWIDTH(C_DWIDTH), .C_N(N)) u_dl (
      .I_clk          (I_clk),
      .I_rst          (I_rst),
      .I_push         (push),
      .I_clr          (clr),
      .I_data         (I_data),
      .O_head         (head),
      .O_head_v       (head_v),
      .O_fill         (fill),
      .O_contents_nxt (contents_nxt)
   );

   always_comb begin
      state_d    = state_q;
      crc_d      = crc_q;
      data_d     = data_q;
      data_v_d   = 1'b0;
      data_eof_d = 1'b0;
      chk_v_d    = 1'b0;
      chk_ok_d   = 1'b0;
      len_err_d  = 1'b0;
      crc_calc_d = crc_calc_q;
      crc_nxt    = f_crc_next(crc_q, head);

      if (I_data_v) begin
         if (I_sof) begin
            crc_d = C_INIT;
            if (I_eof) begin
               chk_v_d    = 1'b1;
               len_err_d  = 1'b1;
               crc_calc_d = f_byte_inv(C_INIT);
               state_d    = ST_IDLE;
            end else begin
               state_d    = (N == 1) ? ST_RUN : ST_FILL;
            end
         end else if (state_q != ST_IDLE) begin
            if (head_v) begin
               crc_d    = crc_nxt;
               data_d   = head;
               data_v_d = 1'b1;
            end
            if (I_eof) begin
               chk_v_d = 1'b1;
               state_d = ST_IDLE;
               if (head_v) begin
                  // After the eof push the line holds exactly the N CRC words.
                  data_eof_d = 1'b1;
                  crc_calc_d = f_byte_inv(crc_nxt);
                  chk_ok_d   = (f_byte_inv(crc_nxt) == contents_nxt);
               end else begin
                  len_err_d  = 1'b1;
                  crc_calc_d = f_byte_inv(crc_q);
               end
            end else if (fill == CW'(N-1)) begin
               state_d = ST_RUN;
            end
         end
      end
   end

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         state_q    <= ST_IDLE;
         crc_q      <= C_INIT;
         data_q     <= '0;
         data_v_q   <= 1'b0;
         data_eof_q <= 1'b0;
         chk_v_q    <= 1'b0;
         chk_ok_q   <= 1'b0;
         len_err_q  <= 1'b0;
         crc_calc_q <= '0;
      end else begin
         state_q    <= state_d;
         crc_q      <= crc_d;
         data_q     <= data_d;
         data_v_q   <= data_v_d;
         data_eof_q <= data_eof_d;
         chk_v_q    <= chk_v_d;
         chk_ok_q   <= chk_ok_d;
         len_err_q  <= len_err_d;
         crc_calc_q <= crc_calc_d;
      end
   end

   assign O_data     = data_q;
   assign O_data_v   = data_v_q;
   assign O_data_eof = data_eof_q;
   assign O_chk_v    = chk_v_q;
   assign O_chk_ok   = chk_ok_q;
   assign O_len_err  = len_err_q;
   assign O_crc_calc = crc_calc_q;

endmodule

// File: tb/tb_crc_check.sv
module tb_crc_check;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // DUT A: CRC-16/CCITT style, 8-bit words (N=2)
   logic [7:0]  a_data, a_odata;
   logic        a_v, a_sof, a_eof, a_odv, a_deof, a_chk_v, a_ok, a_len;
   logic [15:0] a_crc;
   // DUT B: 32-bit CRC, complemented trailer (N=4)
   logic [7:0]  b_data, b_odata;
   logic        b_v, b_sof, b_eof, b_odv, b_deof, b_chk_v, b_ok, b_len;
   logic [31:0] b_crc;

   crc_check #(.C_DWIDTH(8), .C_GEN_WIDTH(16), .C_GEN_SEQ(16'h1021),
               .C_INIT(16'hFFFF), .C_IN_INVERT(1)) dut_a (
      .I_clk(clk), .I_rst(rst), .I_data(a_data), .I_data_v(a_v), .I_sof(a_sof), .I_eof(a_eof),
      .O_data(a_odata), .O_data_v(a_odv), .O_data_eof(a_deof), .O_chk_v(a_chk_v),
      .O_chk_ok(a_ok), .O_len_err(a_len), .O_crc_calc(a_crc));

   crc_check #(.C_DWIDTH(8), .C_GEN_WIDTH(32), .C_BIT_REVERSE(1)) dut_b (
      .I_clk(clk), .I_rst(rst), .I_data(b_data), .I_data_v(b_v), .I_sof(b_sof), .I_eof(b_eof),
      .O_data(b_odata), .O_data_v(b_odv), .O_data_eof(b_deof), .O_chk_v(b_chk_v),
      .O_chk_ok(b_ok), .O_len_err(b_len), .O_crc_calc(b_crc));

   typedef struct {
      logic        ok;
      logic        len;
      logic        eof;
      logic [31:0] crc;
      int          cyc;
   } verd_t;

   typedef struct {
      int               len;
      logic [11:0][7:0] w;
      logic             ok;
      logic             len_err;
      int               np;
      logic [15:0]      crc;
      logic             chk_crc;
   } vec_t;

   verd_t      va_q[$], vb_q[$];
   verd_t      va_t, vb_t;
   logic [7:0] pa_q[$], pb_q[$];
   int         orphan_eof = 0;
   int         checks = 0, errors = 0;
   int         eof_cyc;
   vec_t       vecs[7];

   // Output monitors, sampled on the falling edge
   always @(negedge clk) begin
      if (a_odv) pa_q.push_back(a_odata);
      if (a_chk_v) begin
         va_t.ok = a_ok; va_t.len = a_len; va_t.eof = a_deof;
         va_t.crc = {16'h0, a_crc}; va_t.cyc = cyc;
         va_q.push_back(va_t);
      end
      if (b_odv) pb_q.push_back(b_odata);
      if (b_chk_v) begin
         vb_t.ok = b_ok; vb_t.len = b_len; vb_t.eof = b_deof;
         vb_t.crc = b_crc; vb_t.cyc = cyc;
         vb_q.push_back(vb_t);
      end
      if ((a_deof && !a_chk_v) || (b_deof && !b_chk_v)) orphan_eof++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drv_a(input logic v, input logic s, input logic e, input logic [7:0] d);
      @(posedge clk); #1;
      a_v = v; a_sof = s; a_eof = e; a_data = d;
   endtask

   task automatic drv_b(input logic v, input logic s, input logic e, input logic [7:0] d);
      @(posedge clk); #1;
      b_v = v; b_sof = s; b_eof = e; b_data = d;
   endtask

   task automatic idle_a(input int n);
      drv_a(1'b0, 1'b0, 1'b0, 8'h00);
      repeat (n) @(posedge clk);
   endtask

   // Gap cycles carry junk data and asserted sof/eof with valid low.
   task automatic send_a(input vec_t v, input logic gaps);
      for (int k = 0; k < v.len; k++) begin
         if (gaps) repeat ($urandom_range(0, 2)) drv_a(1'b0, 1'b1, 1'b1, 8'($urandom));
         drv_a(1'b1, k == 0, k == v.len - 1, v.w[k]);
         if (k == v.len - 1) eof_cyc = cyc + 1;
      end
      idle_a(3);
   endtask

   task automatic check_vec(input vec_t v, input string tag);
      chk($sformatf("%s nverdict", tag), va_q.size(), 1);
      if (va_q.size() > 0) begin
         chk($sformatf("%s ok", tag), {31'h0, va_q[0].ok}, {31'h0, v.ok});
         chk($sformatf("%s len_err", tag), {31'h0, va_q[0].len}, {31'h0, v.len_err});
         chk($sformatf("%s data_eof", tag), {31'h0, va_q[0].eof}, (v.np > 0) ? 32'd1 : 32'd0);
         chk($sformatf("%s latency", tag), va_q[0].cyc, eof_cyc);
         if (v.chk_crc) chk($sformatf("%s crc_calc", tag), va_q[0].crc, {16'h0, v.crc});
      end
      chk($sformatf("%s npayload", tag), pa_q.size(), v.np);
      for (int j = 0; j < v.np && j < pa_q.size(); j++)
         chk($sformatf("%s payload[%0d]", tag, j), {24'h0, pa_q[j]}, {24'h0, v.w[j]});
   endtask

   function automatic logic [31:0] m_crc32(input logic [31:0] c, input logic [7:0] d);
      logic fb;
      for (int i = 0; i < 8; i++) begin
         fb = c[31] ^ d[i];
         c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
      end
      return c;
   endfunction

   // Test-6 working storage
   logic [7:0]  frm[$];
   logic [7:0]  pb_exp[$];
   logic [31:0] exp_crc[3];
   logic        exp_ok[3];
   int          eofc[3];
   int          plen[3];
   logic [31:0] c32, t32;
   logic [7:0]  d8;

   initial begin
      // ---------------- vector table (DUT A) ----------------
      vecs[0].len = 11; vecs[0].w = '0;
      for (int k = 0; k < 9; k++) vecs[0].w[k] = 8'h31 + 8'(k);
      vecs[0].w[9] = 8'h29; vecs[0].w[10] = 8'hB1;
      vecs[0].ok = 1'b1; vecs[0].len_err = 1'b0; vecs[0].np = 9;
      vecs[0].crc = 16'h29B1; vecs[0].chk_crc = 1'b1;
      vecs[1] = vecs[0]; vecs[1].w[4] = 8'h34; vecs[1].ok = 1'b0; vecs[1].chk_crc = 1'b0;
      vecs[2] = vecs[0]; vecs[2].w[10] = 8'hB0; vecs[2].ok = 1'b0;
      vecs[3].len = 2; vecs[3].w = '0; vecs[3].w[0] = 8'h29; vecs[3].w[1] = 8'hB1;
      vecs[3].ok = 1'b0; vecs[3].len_err = 1'b1; vecs[3].np = 0;
      vecs[3].crc = 16'h0; vecs[3].chk_crc = 1'b0;
      vecs[4] = vecs[3]; vecs[4].len = 1; vecs[4].w[0] = 8'h31;
      vecs[5].len = 3; vecs[5].w = '0;
      vecs[5].w[0] = 8'h31; vecs[5].w[1] = 8'hC7; vecs[5].w[2] = 8'h82;
      vecs[5].ok = 1'b1; vecs[5].len_err = 1'b0; vecs[5].np = 1;
      vecs[5].crc = 16'hC782; vecs[5].chk_crc = 1'b1;
      vecs[6] = vecs[5]; vecs[6].w[2] = 8'h83; vecs[6].ok = 1'b0;

      // ---------------- reset ----------------
      rst = 1'b1;
      a_v = 0; a_sof = 0; a_eof = 0; a_data = 0;
      b_v = 0; b_sof = 0; b_eof = 0; b_data = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset a_outs", {a_odv, a_deof, a_chk_v, a_ok, a_len, 8'h0, a_odata, a_crc},
          32'h0);
      chk("reset b_crc", b_crc, 32'h0);
      chk("reset b_outs", {b_odv, b_deof, b_chk_v, b_ok, b_len, 19'h0, b_odata}, 32'h0);

      // ---------------- table-driven frames ----------------
      for (int i = 0; i < 7; i++) begin
         va_q.delete(); pa_q.delete();
         send_a(vecs[i], 1'b0);
         check_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // ---------------- idle-dropped words, then sof mid-frame ----------------
      va_q.delete(); pa_q.delete();
      drv_a(1'b1, 1'b0, 1'b0, 8'h55);
      drv_a(1'b1, 1'b0, 1'b1, 8'h66);
      drv_a(1'b1, 1'b0, 1'b0, 8'h77);
      idle_a(3);
      chk("idle drop nverdict", va_q.size(), 0);
      chk("idle drop npayload", pa_q.size(), 0);
      for (int k = 0; k < 4; k++) drv_a(1'b1, k == 0, 1'b0, 8'h31 + 8'(k));
      send_a(vecs[0], 1'b0);
      chk("restart nverdict", va_q.size(), 1);
      if (va_q.size() > 0) chk("restart ok", {31'h0, va_q[0].ok}, 32'd1);
      chk("restart npayload", pa_q.size(), 2 + 9);

      // ---------------- gaps ----------------
      va_q.delete(); pa_q.delete();
      send_a(vecs[0], 1'b1);
      check_vec(vecs[0], "gaps");

      // ---------------- reset mid-frame ----------------
      va_q.delete(); pa_q.delete();
      for (int k = 0; k < 5; k++) drv_a(1'b1, k == 0, 1'b0, 8'h31 + 8'(k));
      @(posedge clk); #1; rst = 1'b1; a_v = 1'b0;
      @(posedge clk); #1; rst = 1'b0;
      chk("midrst outs", {a_odv, a_deof, a_chk_v, a_ok, a_len, 8'h0, a_odata, a_crc}, 32'h0);
      repeat (3) @(posedge clk);
      chk("midrst nverdict", va_q.size(), 0);
      va_q.delete(); pa_q.delete();
      send_a(vecs[0], 1'b0);
      check_vec(vecs[0], "postrst");

      // ---------------- DUT B: back-to-back CRC32 frames ----------------
      plen[0] = 1; plen[1] = 4; plen[2] = 7;
      vb_q.delete(); pb_q.delete(); pb_exp.delete();
      for (int f = 0; f < 3; f++) begin
         frm.delete();
         c32 = 32'hFFFFFFFF;
         for (int k = 0; k < plen[f]; k++) begin
            d8 = 8'($urandom);
            frm.push_back(d8); pb_exp.push_back(d8);
            c32 = m_crc32(c32, d8);
         end
         t32 = ~c32;
         exp_crc[f] = t32;
         exp_ok[f]  = (f != 1);
         frm.push_back(t32[31:24]); frm.push_back(t32[23:16]);
         frm.push_back(t32[15:8]);
         frm.push_back((f == 1) ? (t32[7:0] ^ 8'h01) : t32[7:0]);
         for (int k = 0; k < frm.size(); k++) begin
            drv_b(1'b1, k == 0, k == frm.size() - 1, frm[k]);
            if (k == frm.size() - 1) eofc[f] = cyc + 1;
         end
      end
      drv_b(1'b0, 1'b0, 1'b0, 8'h00);
      repeat (3) @(posedge clk);
      chk("b2b nverdict", vb_q.size(), 3);
      for (int f = 0; f < 3 && f < vb_q.size(); f++) begin
         chk($sformatf("b2b%0d ok", f), {31'h0, vb_q[f].ok}, {31'h0, exp_ok[f]});
         chk($sformatf("b2b%0d len_err", f), {31'h0, vb_q[f].len}, 32'd0);
         chk($sformatf("b2b%0d data_eof", f), {31'h0, vb_q[f].eof}, 32'd1);
         chk($sformatf("b2b%0d crc_calc", f), vb_q[f].crc, exp_crc[f]);
         chk($sformatf("b2b%0d latency", f), vb_q[f].cyc, eofc[f]);
      end
      chk("b2b npayload", pb_q.size(), pb_exp.size());
      for (int j = 0; j < pb_exp.size() && j < pb_q.size(); j++)
         chk($sformatf("b2b payload[%0d]", j), {24'h0, pb_q[j]}, {24'h0, pb_exp[j]});

      chk("eof without verdict", orphan_eof, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
